// File: rtl/dp_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : dp_operand_stage
//  Purpose  : Builds ALU operands (Rn, shifter operand, shifter carry) for ARM
//             data-processing instructions behind a valid/ready handshake.
//             Define REG_SHIFT_SINGLE_CYCLE_EN to compute register-specified
//             shifts at accept instead of in an extra SHIFT cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module dp_operand_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    input  logic [N-1:0] rn_val,
    input  logic [N-1:0] rm_val,
    input  logic [N-1:0] rs_val,
    input  logic         c_flag_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   opcode,
    output logic [N-1:0] operand_1,
    output logic [N-1:0] operand_2,
    output logic         c_from_shifter,
    output logic         set_flags,
    output logic [3:0]   rd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_out_valid;
    logic [3:0]     r_opcode;
    logic [N-1:0]   r_operand_1;
    logic [N-1:0]   r_operand_2;
    logic           r_c_from_shifter;
    logic           r_set_flags;
    logic [3:0]     r_rd;

    logic           w_accept;
    logic           w_defer;
    logic           w_src_imm;
    logic [11:0]    w_src_sh;
    logic [N-1:0]   w_src_rm;
    logic [7:0]     w_src_rs;
    logic           w_src_c;
    logic [N:0]     w_shift;
    logic           w_unused;

    // Shifter helpers return {carry, result}; amounts up to N are legal.
    function automatic logic [N:0] f_lsl(input logic [N-1:0] v, input logic [5:0] n);
        logic [N:0] t;
        t = {1'b0, v} << n;
        return t;
    endfunction

    function automatic logic [N:0] f_lsr(input logic [N-1:0] v, input logic [5:0] n);
        logic [N:0] t;
        t = {v, 1'b0} >> n;
        return {t[0], t[N:1]};
    endfunction

    function automatic logic [N:0] f_asr(input logic [N-1:0] v, input logic [5:0] n);
        logic signed [N:0] t;
        t = $signed({v, 1'b0}) >>> n;
        return {t[0], t[N:1]};
    endfunction

    function automatic logic [N:0] f_ror(input logic [N-1:0] v, input logic [4:0] n);
        logic [2*N-1:0] t;
        t = {v, v} >> n;
        return {t[N-1], t[N-1:0]};
    endfunction

    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef REG_SHIFT_SINGLE_CYCLE_EN
    assign w_defer   = 1'b0;
    assign w_src_imm = instr[25];
    assign w_src_sh  = instr[11:0];
    assign w_src_rm  = rm_val;
    assign w_src_rs  = rs_val[7:0];
    assign w_src_c   = c_flag_in;
`else
    logic [1:0]     r_cap_type;
    logic [N-1:0]   r_cap_rm;
    logic [7:0]     r_cap_rs;
    logic           r_cap_c;
    logic           w_in_shift;

    assign w_defer    = ~instr[25] & instr[4];
    assign w_in_shift = (r_state == ST_SHIFT);
    // In SHIFT the shifter is fed from the captured operands, re-encoded as a register shift.
    assign w_src_imm  = w_in_shift ? 1'b0 : instr[25];
    assign w_src_sh   = w_in_shift ? {5'd0, r_cap_type, 1'b1, 4'd0} : instr[11:0];
    assign w_src_rm   = w_in_shift ? r_cap_rm : rm_val;
    assign w_src_rs   = w_in_shift ? r_cap_rs : rs_val[7:0];
    assign w_src_c    = w_in_shift ? r_cap_c  : c_flag_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_type <= 2'd0;
            r_cap_rm   <= '0;
            r_cap_rs   <= 8'd0;
            r_cap_c    <= 1'b0;
        end else if (w_accept && w_defer) begin
            r_cap_type <= instr[6:5];
            r_cap_rm   <= rm_val;
            r_cap_rs   <= rs_val[7:0];
            r_cap_c    <= c_flag_in;
        end
    end
`endif

    always_comb begin
        w_shift = {w_src_c, w_src_rm};
        if (w_src_imm) begin
            w_shift = f_ror({{(N-8){1'b0}}, w_src_sh[7:0]}, {w_src_sh[11:8], 1'b0});
            if (w_src_sh[11:8] == 4'd0) begin
                w_shift[N] = w_src_c;
            end
        end else if (!w_src_sh[4]) begin
            // Immediate shift: amount 0 encodes LSR/ASR #32 and RRX.
            case (w_src_sh[6:5])
                2'b00: w_shift = (w_src_sh[11:7] == 5'd0) ? {w_src_c, w_src_rm}
                                                          : f_lsl(w_src_rm, {1'b0, w_src_sh[11:7]});
                2'b01: w_shift = f_lsr(w_src_rm, (w_src_sh[11:7] == 5'd0) ? 6'd32 : {1'b0, w_src_sh[11:7]});
                2'b10: w_shift = f_asr(w_src_rm, (w_src_sh[11:7] == 5'd0) ? 6'd32 : {1'b0, w_src_sh[11:7]});
                default: w_shift = (w_src_sh[11:7] == 5'd0) ? {w_src_rm[0], w_src_c, w_src_rm[N-1:1]}
                                                            : f_ror(w_src_rm, w_src_sh[11:7]);
            endcase
        end else if (w_src_rs != 8'd0) begin
            case (w_src_sh[6:5])
                2'b00: w_shift = (w_src_rs <= 8'd32) ? f_lsl(w_src_rm, w_src_rs[5:0]) : '0;
                2'b01: w_shift = (w_src_rs <= 8'd32) ? f_lsr(w_src_rm, w_src_rs[5:0]) : '0;
                2'b10: w_shift = f_asr(w_src_rm, (w_src_rs >= 8'd32) ? 6'd32 : w_src_rs[5:0]);
                default: w_shift = (w_src_rs[4:0] == 5'd0) ? {w_src_rm[N-1], w_src_rm}
                                                           : f_ror(w_src_rm, w_src_rs[4:0]);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_out_valid      <= 1'b0;
            r_opcode         <= 4'd0;
            r_operand_1      <= '0;
            r_operand_2      <= '0;
            r_c_from_shifter <= 1'b0;
            r_set_flags      <= 1'b0;
            r_rd             <= 4'd0;
        end else if (w_accept) begin
            r_opcode    <= instr[24:21];
            r_operand_1 <= rn_val;
            r_set_flags <= instr[20];
            r_rd        <= instr[15:12];
            if (w_defer) begin
                r_state     <= ST_SHIFT;
                r_out_valid <= 1'b0;
            end else begin
                r_operand_2      <= w_shift[N-1:0];
                r_c_from_shifter <= w_shift[N];
                r_state          <= ST_OUT;
                r_out_valid      <= 1'b1;
            end
`ifndef REG_SHIFT_SINGLE_CYCLE_EN
        end else if (r_state == ST_SHIFT) begin
            r_operand_2      <= w_shift[N-1:0];
            r_c_from_shifter <= w_shift[N];
            r_state          <= ST_OUT;
            r_out_valid      <= 1'b1;
`endif
        end else if ((r_state == ST_OUT) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign opcode         = r_opcode;
    assign operand_1      = r_operand_1;
    assign operand_2      = r_operand_2;
    assign c_from_shifter = r_c_from_shifter;
    assign set_flags      = r_set_flags;
    assign rd             = r_rd;

    assign w_unused = ^{instr[31:26], instr[19:16], instr[3:0], rs_val[N-1:8]};

endmodule
`default_nettype wire

// File: tb/tb_dp_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_operand_stage
//  Purpose  : Scoreboard bench for dp_operand_stage (default 2-cycle register shift).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dp_operand_stage;

    typedef struct packed {
        logic [31:0] op2;
        logic        c;
        logic [31:0] op1;
        logic [3:0]  opc;
        logic        s;
        logic [3:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] rn_val = 32'd0;
    logic [31:0] rm_val = 32'd0;
    logic [31:0] rs_val = 32'd0;
    logic        c_flag_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  opcode;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        c_from_shifter;
    logic        set_flags;
    logic [3:0]  rd;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dp_operand_stage #(.N(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rn_val(rn_val), .rm_val(rm_val), .rs_val(rs_val),
        .c_flag_in(c_flag_in), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .operand_1(operand_1), .operand_2(operand_2),
        .c_from_shifter(c_from_shifter), .set_flags(set_flags), .rd(rd)
    );

    function automatic logic [31:0] mk_imm(logic [3:0] op, logic s, logic [3:0] d,
                                           logic [3:0] rot, logic [7:0] imm);
        return {6'd0, 1'b1, op, s, 4'd0, d, rot, imm};
    endfunction

    function automatic logic [31:0] mk_ish(logic [3:0] op, logic s, logic [3:0] d,
                                           logic [4:0] amt, logic [1:0] typ);
        return {6'd0, 1'b0, op, s, 4'd0, d, amt, typ, 1'b0, 4'd0};
    endfunction

    function automatic logic [31:0] mk_rsh(logic [3:0] op, logic s, logic [3:0] d, logic [1:0] typ);
        return {6'd0, 1'b0, op, s, 4'd0, d, 4'd0, 1'b0, typ, 1'b1, 4'd0};
    endfunction

    // Reference shifter written straight from the ARM rules, returns {carry, result}.
    function automatic logic [32:0] ref_shift(logic [31:0] ins, logic [31:0] rm,
                                              logic [31:0] rs, logic cin);
        logic [31:0] r;
        logic [31:0] imm;
        logic        c;
        int          a;
        r = rm;
        c = cin;
        if (ins[25]) begin
            imm = {24'd0, ins[7:0]};
            a   = 2 * int'(ins[11:8]);
            if (a == 0) begin
                r = imm;
                c = cin;
            end else begin
                r = (imm >> a) | (imm << (32 - a));
                c = r[31];
            end
        end else if (!ins[4]) begin
            a = int'(ins[11:7]);
            case (ins[6:5])
                2'b00: if (a != 0) begin r = rm << a; c = rm[32-a]; end
                2'b01: if (a == 0) begin r = 32'd0; c = rm[31]; end
                       else begin r = rm >> a; c = rm[a-1]; end
                2'b10: if (a == 0) begin r = {32{rm[31]}}; c = rm[31]; end
                       else begin r = $signed(rm) >>> a; c = rm[a-1]; end
                default: if (a == 0) begin r = {cin, rm[31:1]}; c = rm[0]; end
                         else begin r = (rm >> a) | (rm << (32 - a)); c = rm[a-1]; end
            endcase
        end else begin
            a = int'(rs[7:0]);
            if (a != 0) begin
                case (ins[6:5])
                    2'b00: if (a < 32) begin r = rm << a; c = rm[32-a]; end
                           else if (a == 32) begin r = 32'd0; c = rm[0]; end
                           else begin r = 32'd0; c = 1'b0; end
                    2'b01: if (a < 32) begin r = rm >> a; c = rm[a-1]; end
                           else if (a == 32) begin r = 32'd0; c = rm[31]; end
                           else begin r = 32'd0; c = 1'b0; end
                    2'b10: if (a >= 32) begin r = {32{rm[31]}}; c = rm[31]; end
                           else begin r = $signed(rm) >>> a; c = rm[a-1]; end
                    default: begin
                        a = a % 32;
                        if (a == 0) begin r = rm; c = rm[31]; end
                        else begin r = (rm >> a) | (rm << (32 - a)); c = rm[a-1]; end
                    end
                endcase
            end
        end
        return {c, r};
    endfunction

    task automatic drive(logic [31:0] ins, logic [31:0] rn, logic [31:0] rm,
                         logic [31:0] rs, logic cin);
        exp_t        e;
        logic [32:0] sh;
        instr     = ins;
        rn_val    = rn;
        rm_val    = rm;
        rs_val    = rs;
        c_flag_in = cin;
        in_valid  = 1'b1;
        sh        = ref_shift(ins, rm, rs, cin);
        e.op2     = sh[31:0];
        e.c       = sh[32];
        e.op1     = rn;
        e.opc     = ins[24:21];
        e.s       = ins[20];
        e.rd      = ins[15:12];
        sb.push_back(e);
    endtask

    // Presents one instruction and returns 1 time unit after the accepting edge.
    task automatic send(logic [31:0] ins, logic [31:0] rn, logic [31:0] rm,
                        logic [31:0] rs, logic cin);
        int k;
        drive(ins, rn, rm, rs, cin);
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, pops the scoreboard, compares, then lets the edge consume it.
    task automatic collect(string name);
        int   k;
        exp_t e;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (!out_valid || sb.size() == 0) begin
            n_err++;
            $display("FAIL %s out_valid_timeout: out_valid=%0b pending=%0d required valid with entry",
                     name, out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (operand_2 !== e.op2) begin n_err++;
                $display("FAIL %s operand_2: got %h required %h", name, operand_2, e.op2); end
            n_cmp++;
            if (c_from_shifter !== e.c) begin n_err++;
                $display("FAIL %s c_from_shifter: got %0b required %0b", name, c_from_shifter, e.c); end
            n_cmp++;
            if ({operand_1, opcode, set_flags, rd} !== {e.op1, e.opc, e.s, e.rd}) begin n_err++;
                $display("FAIL %s fields: got op1=%h opc=%h s=%0b rd=%h required op1=%h opc=%h s=%0b rd=%h",
                         name, operand_1, opcode, set_flags, rd, e.op1, e.opc, e.s, e.rd); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_handshake: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready); end
        n_cmp++;
        if ({opcode, operand_1, operand_2, c_from_shifter, set_flags, rd} !== 74'd0) begin n_err++;
            $display("FAIL reset_outputs: got op1=%h op2=%h opc=%h c=%0b s=%0b rd=%h required all 0",
                     operand_1, operand_2, opcode, c_from_shifter, set_flags, rd); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_immediate();
        send(mk_imm(4'hD, 1'b1, 4'h3, 4'd4, 8'hFF), 32'h1234_5678, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++;
            $display("FAIL imm_latency: out_valid=%0b required 1", out_valid); end
        collect("imm_rot4");
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL imm_idle: out_valid=%0b required 0", out_valid); end
        send(mk_imm(4'h4, 1'b0, 4'hE, 4'd0, 8'hA5), 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1);
        collect("imm_rot0");
    endtask

    task automatic test_imm_shift();
        send(mk_ish(4'h2, 1'b1, 4'h1, 5'd0, 2'b01), 32'h1, 32'h8000_0001, 32'h0, 1'b0);
        collect("lsr0");
        send(mk_ish(4'h2, 1'b1, 4'h1, 5'd0, 2'b11), 32'h2, 32'h0000_0002, 32'h0, 1'b1);
        collect("rrx");
        send(mk_ish(4'h0, 1'b0, 4'h2, 5'd0, 2'b10), 32'h3, 32'h8000_0000, 32'h0, 1'b0);
        collect("asr0");
        send(mk_ish(4'h0, 1'b0, 4'h2, 5'd0, 2'b00), 32'h4, 32'hCAFE_F00D, 32'h0, 1'b1);
        collect("lsl0");
        for (int i = 0; i < 12; i++) begin
            send(mk_ish(4'(i), 1'(i), 4'(i), 5'($urandom_range(1, 31)), 2'(i)),
                 $urandom, $urandom, $urandom, 1'($urandom));
            collect("imm_shift_rand");
        end
    endtask

    task automatic test_reg_shift();
        logic [7:0] amts [8] = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255, 8'd17};
        send(mk_rsh(4'h1, 1'b1, 4'h7, 2'b00), 32'h55, 32'hFFFF_FFFF, 32'd33, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++;
            $display("FAIL regshift_shift_state: out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++;
            $display("FAIL regshift_latency: out_valid=%0b required 1", out_valid); end
        collect("reg_lsl33");
        send(mk_rsh(4'h1, 1'b1, 4'h7, 2'b00), 32'h56, 32'hFFFF_FFFF, 32'h0000_0120, 1'b0);
        collect("reg_lsl32");
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 8; j++) begin
                send(mk_rsh(4'(j), 1'(t), 4'(j + t), 2'(t)), $urandom,
                     (j == 7) ? 32'h8000_0001 : $urandom, {$urandom_range(0, 255) << 8, amts[j]},
                     1'($urandom));
                collect("reg_shift_sweep");
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        send(mk_imm(4'h8, 1'b0, 4'h5, 4'd1, 8'h03), 32'hAAAA_0001, 32'h0, 32'h0, 1'b0);
        drive(mk_imm(4'h9, 1'b1, 4'h6, 4'd15, 8'h81), 32'hBBBB_0002, 32'h0, 32'h0, 1'b0);
        e = sb[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || operand_2 !== e.op2 || operand_1 !== e.op1) begin
                n_err++;
                $display("FAIL hold_stable: valid=%0b in_ready=%0b op2=%h op1=%h required 1/0/%h/%h",
                         out_valid, in_ready, operand_2, operand_1, e.op2, e.op1);
            end
        end
        out_ready = 1'b1;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (in_ready !== 1'b1 || c_from_shifter !== e.c) begin n_err++;
            $display("FAIL hold_release: in_ready=%0b c=%0b required 1/%0b", in_ready, c_from_shifter, e.c); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++;
            $display("FAIL consume_accept_valid: out_valid=%0b required 1", out_valid); end
        collect("after_consume_accept");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(mk_imm(4'(i), 1'(i), 4'(15 - i), 4'($urandom), 8'($urandom)), $urandom, 32'h0, 32'h0,
                  1'($urandom));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || operand_2 !== e.op2 || c_from_shifter !== e.c || operand_1 !== e.op1) begin
                n_err++;
                $display("FAIL b2b_%0d: valid=%0b op2=%h c=%0b op1=%h required 1/%h/%0b/%h",
                         i, out_valid, operand_2, c_from_shifter, operand_1, e.op2, e.c, e.op1);
            end
        end
        drive(mk_rsh(4'hF, 1'b1, 4'h9, 2'b11), 32'h77, 32'h1234_5678, 32'd36, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++;
            $display("FAIL b2b_to_shift: out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready); end
        collect("b2b_reg_ror");
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        send(mk_rsh(4'h3, 1'b1, 4'h2, 2'b01), 32'h99, 32'hF0F0_F0F0, 32'd4, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || operand_2 !== 32'd0) begin n_err++;
            $display("FAIL reset_mid_shift: out_valid=%0b in_ready=%0b op2=%h required 0/1/0",
                     out_valid, in_ready, operand_2); end
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++;
                $display("FAIL reset_no_issue: out_valid=%0b required 0", out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_imm_shift();
        test_reg_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
